count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Monitor on the output side of the four-bit up/down synchronous counter. It samples the counter's `count` value, infers the counting direction, and locks once the sequence is consistent. In lock it flags direction reversals, wrap-around events and illegal jumps, and keeps a saturating error count. It sits alongside the counter in simulation and on-chip as a self-check / status block.

## Interface
- `WIDTH`, 4: width of the observed count.
- `LOCK_CNT`, 3: consecutive same-direction steps required to lock; legal range 1 to 15.
- `ERR_W`, 8: width of the error counter.
- `clk`  input  1  single clock, rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  `count_in` holds a new sample this cycle.
- `count_in`  input  WIDTH  observed counter value.
- `locked`  output  1  sequence is locked.
- `dir`  output  1  locked direction: 1 = up, 0 = down.
- `wrap_pulse`  output  1  one-cycle pulse on a legal wrap while locked.
- `rev_pulse`  output  1  one-cycle pulse on a direction reversal while locked.
- `err_pulse`  output  1  one-cycle pulse on an illegal jump while locked.
- `err_count`  output  ERR_W  number of errors, saturating.

## Operation
- Step classification: `delta = (count_in - prev) mod 2^WIDTH`.
  - delta = 1 is UP.
  - delta = 2^WIDTH-1 is DOWN.
  - delta = 0 is HOLD.
  - Any other delta is JUMP.
- `prev` updates to `count_in` on every valid sample.
- Internal run counter `run` is 0 to LOCK_CNT. `cand` is the candidate direction.
- States:
  - UNSYNC: first valid sample loads `prev` and moves to ACQUIRE with run=0. No step is classified in this state.
  - ACQUIRE:
    - UP or DOWN matching `cand`: run+1.
    - UP or DOWN with a different direction, or with run=0: `cand` takes the new direction and run=1.
    - HOLD: no change.
    - JUMP: run=0.
    - If the updated run equals LOCK_CNT: go to LOCKED, set `locked`=1, and load `dir`=`cand` in the same update.
  - LOCKED:
    - HOLD or a step matching `dir`: stay in LOCKED.
    - Step opposite to `dir`: flip `dir`, pulse `rev_pulse`, stay in LOCKED.
    - JUMP: pulse `err_pulse`, increment `err_count`, clear `locked`, go to ACQUIRE with run=0. The jump sample becomes the new `prev`.
- `wrap_pulse` fires only in LOCKED, on an UP step from 2^WIDTH-1 to 0 or a DOWN step from 0 to 2^WIDTH-1. This includes the reversal case, where `rev_pulse` and `wrap_pulse` assert together.
- `err_count` saturates at 2^ERR_W-1. `err_pulse` still fires when it is saturated.
- `in_valid`=0: no state, `prev`, `run` or output change, and all pulses are 0.
- Errors are counted only in LOCKED. A JUMP in ACQUIRE is silent.

## Timing
- All outputs are registered. A sample valid in cycle N is reflected on the outputs after the rising edge that ends cycle N. Latency is 1.
- Pulses are high for exactly one cycle per triggering sample. Back-to-back valid samples can produce back-to-back pulses.
- Lock time with the counter running continuously: 1 + LOCK_CNT valid samples. For LOCK_CNT=3, `locked` rises after the 4th sample.
- Reset (`rstn`=0, asynchronous, at any time including mid-acquire or while locked) forces these values immediately:
  - state = UNSYNC, `prev`=0, run=0, `cand`=1.
  - `locked`=0, `dir`=1, `err_count`=0, all pulses 0.
- After `rstn` deasserts, the first valid sample is treated as the UNSYNC sample.

## Test plan
- Reset, then samples 0,1,2,3 with `in_valid`=1 every cycle: `locked`=1 and `dir`=1 after the 4th sample; `err_count`=0.
- After lock on 13,14,15, continue with sample 0: `wrap_pulse`=1 for one cycle; `locked` stays 1.
- Sequence 5,4,3,2, then 3: lock with `dir`=0; on sample 3, `rev_pulse`=1 and `dir`=1.
- Locked up at 6, then sample 9: `err_pulse`=1, `err_count`=1, `locked`=0. Then 10,11,12 relocks up after sample 12.
- Samples 0,1,2 with `in_valid` low for 5 cycles between each sample and `count_in` driven to garbage during those cycles: no effect from the invalid cycles. Then sample 3: lock. Separately, sample 7 repeated 4 times (HOLD) while locked: no pulses.
- With ERR_W=2, force 4 jumps, relocking between each: `err_count` reads 1,2,3,3 and `err_pulse` fires all 4 times. Then assert `rstn`=0 mid-sequence: all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
// Watches the output of an up/down counter, infers its counting direction and
// locks once LOCK_CNT consecutive steps agree. While locked it flags direction
// reversals, legal wrap-arounds and illegal jumps, and keeps a saturating
// error count.
//
// Ports:
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   in_valid   : count_in carries a new sample this cycle
//   count_in   : observed counter value
//   locked     : sequence is locked
//   dir        : locked direction (1 = up, 0 = down)
//   wrap_pulse : one-cycle pulse on a legal wrap while locked
//   rev_pulse  : one-cycle pulse on a direction reversal while locked
//   err_pulse  : one-cycle pulse on an illegal jump while locked
//   err_count  : saturating count of illegal jumps seen while locked
//
// state    | meaning
// ---------+----------------------------------------------------------
// UNSYNC   | waiting for the first sample to seed prev
// ACQUIRE  | counting consecutive same-direction steps toward lock
// LOCKED_S | sequence consistent; reversals, wraps and jumps reported

module count_sequence_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             dir,
  output logic             wrap_pulse,
  output logic             rev_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  // LOCK_CNT is at most 15, so four bits always hold the run length.
  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    UNSYNC   = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED_S = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;
  logic             cand;

  logic [WIDTH-1:0] delta;
  logic             is_up;
  logic             is_dn;
  logic             is_hold;
  logic             is_jump;
  logic [RUN_W-1:0] run_nxt;
  logic             cand_nxt;

  always_comb begin
    delta   = count_in - prev;
    is_up   = (delta == WIDTH'(1));
    is_dn   = (delta == MAX_VAL);
    is_hold = (delta == '0);
    is_jump = !(is_up || is_dn || is_hold);

    run_nxt  = run;
    cand_nxt = cand;
    if (is_up || is_dn) begin
      // A fresh run (run == 0) always restarts, even if the direction matches cand.
      if ((run != '0) && (is_up == cand)) begin
        run_nxt = run + 1'b1;
      end else begin
        cand_nxt = is_up;
        run_nxt  = RUN_W'(1);
      end
    end else if (is_jump) begin
      run_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= UNSYNC;
      prev       <= '0;
      run        <= '0;
      cand       <= 1'b1;
      locked     <= 1'b0;
      dir        <= 1'b1;
      wrap_pulse <= 1'b0;
      rev_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      rev_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
      if (in_valid) begin
        prev <= count_in;
        case (state)
          UNSYNC: begin
            state <= ACQUIRE;
            run   <= '0;
          end
          ACQUIRE: begin
            run  <= run_nxt;
            cand <= cand_nxt;
            if (run_nxt == LOCK_RUN) begin
              state  <= LOCKED_S;
              locked <= 1'b1;
              dir    <= cand_nxt;
            end
          end
          LOCKED_S: begin
            if (is_jump) begin
              err_pulse <= 1'b1;
              if (err_count != ERR_MAX) begin
                err_count <= err_count + 1'b1;
              end
              locked <= 1'b0;
              state  <= ACQUIRE;
              run    <= '0;
            end else if (is_up) begin
              if (!dir) begin
                dir       <= 1'b1;
                rev_pulse <= 1'b1;
              end
              if (prev == MAX_VAL) begin
                wrap_pulse <= 1'b1;
              end
            end else if (is_dn) begin
              if (dir) begin
                dir       <= 1'b0;
                rev_pulse <= 1'b1;
              end
              if (prev == '0) begin
                wrap_pulse <= 1'b1;
              end
            end
          end
          default: begin
            state <= UNSYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
module tb_count_sequence_checker;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [3:0] count_in;

  logic       locked, dir, wrap_pulse, rev_pulse, err_pulse;
  logic [7:0] err_count;
  logic       locked2, dir2, wrap_pulse2, rev_pulse2, err_pulse2;
  logic [1:0] err_count2;

  int checks;
  int errors;

  count_sequence_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .count_in(count_in),
    .locked(locked), .dir(dir), .wrap_pulse(wrap_pulse), .rev_pulse(rev_pulse),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  count_sequence_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .count_in(count_in),
    .locked(locked2), .dir(dir2), .wrap_pulse(wrap_pulse2), .rev_pulse(rev_pulse2),
    .err_pulse(err_pulse2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [3:0] c);
    @(negedge clk);
    in_valid = v;
    count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    count_in = 4'd0;
    @(posedge clk);
    #1;
    checks++;
    if ({locked, dir, wrap_pulse, rev_pulse, err_pulse} !== 5'b01000 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got l=%b d=%b w=%b r=%b e=%b cnt=%0d exp l=0 d=1 w=0 r=0 e=0 cnt=0",
               locked, dir, wrap_pulse, rev_pulse, err_pulse, err_count);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_lock_up();
    do_reset();
    step(1, 4'd0);
    step(1, 4'd1);
    step(1, 4'd2);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_up_early got locked=%b exp 0", locked);
    end
    step(1, 4'd3);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL lock_up got l=%b d=%b cnt=%0d exp l=1 d=1 cnt=0", locked, dir, err_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 4'd12);
    step(1, 4'd13);
    step(1, 4'd14);
    step(1, 4'd15);
    checks++;
    if (locked !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_prelock got l=%b w=%b exp l=1 w=0", locked, wrap_pulse);
    end
    step(1, 4'd0);
    checks++;
    if (wrap_pulse !== 1'b1 || locked !== 1'b1 || rev_pulse !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up got w=%b l=%b r=%b e=%b exp w=1 l=1 r=0 e=0",
               wrap_pulse, locked, rev_pulse, err_pulse);
    end
    step(1, 4'd1);
    checks++;
    if (wrap_pulse !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL wrap_one_cycle got w=%b l=%b exp w=0 l=1", wrap_pulse, locked);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    step(1, 4'd5);
    step(1, 4'd4);
    step(1, 4'd3);
    step(1, 4'd2);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL lock_down got l=%b d=%b exp l=1 d=0", locked, dir);
    end
    step(1, 4'd3);
    checks++;
    if (rev_pulse !== 1'b1 || dir !== 1'b1 || wrap_pulse !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL reverse got r=%b d=%b w=%b l=%b exp r=1 d=1 w=0 l=1",
               rev_pulse, dir, wrap_pulse, locked);
    end
    step(1, 4'd4);
    checks++;
    if (rev_pulse !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL reverse_one_cycle got r=%b d=%b exp r=0 d=1", rev_pulse, dir);
    end
  endtask

  task automatic test_rev_wrap();
    do_reset();
    step(1, 4'd2);
    step(1, 4'd1);
    step(1, 4'd0);
    step(1, 4'd15);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rev_wrap_lock got l=%b d=%b w=%b exp l=1 d=0 w=0", locked, dir, wrap_pulse);
    end
    step(1, 4'd0);
    checks++;
    if (rev_pulse !== 1'b1 || wrap_pulse !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rev_wrap_up got r=%b w=%b d=%b exp r=1 w=1 d=1", rev_pulse, wrap_pulse, dir);
    end
    step(1, 4'd15);
    checks++;
    if (rev_pulse !== 1'b1 || wrap_pulse !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL rev_wrap_down got r=%b w=%b d=%b exp r=1 w=1 d=0", rev_pulse, wrap_pulse, dir);
    end
  endtask

  task automatic test_jump();
    do_reset();
    step(1, 4'd3);
    step(1, 4'd4);
    step(1, 4'd5);
    step(1, 4'd6);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL jump_prelock got l=%b d=%b exp l=1 d=1", locked, dir);
    end
    step(1, 4'd9);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL jump got e=%b cnt=%0d l=%b exp e=1 cnt=1 l=0", err_pulse, err_count, locked);
    end
    step(1, 4'd10);
    step(1, 4'd11);
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL relock_early got l=%b e=%b exp l=0 e=0", locked, err_pulse);
    end
    step(1, 4'd12);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL relock got l=%b d=%b cnt=%0d exp l=1 d=1 cnt=1", locked, dir, err_count);
    end
  endtask

  task automatic test_invalid_and_hold();
    logic [3:0] garbage [5] = '{4'd9, 4'd15, 4'd4, 4'd11, 4'd6};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step(1, 4'(s));
      for (int g = 0; g < 5; g++) begin
        step(0, garbage[g]);
        checks++;
        if (locked !== 1'b0 || {wrap_pulse, rev_pulse, err_pulse} !== 3'b000 || err_count !== 8'd0) begin
          errors++;
          $display("FAIL invalid_gap s=%0d g=%0d got l=%b pulses=%b cnt=%0d exp l=0 pulses=000 cnt=0",
                   s, g, locked, {wrap_pulse, rev_pulse, err_pulse}, err_count);
        end
      end
    end
    step(1, 4'd3);
    checks++;
    if (locked !== 1'b1 || dir !== 1'b1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL invalid_lock got l=%b d=%b cnt=%0d exp l=1 d=1 cnt=0", locked, dir, err_count);
    end
    step(1, 4'd4);
    step(1, 4'd5);
    step(1, 4'd6);
    step(1, 4'd7);
    for (int h = 0; h < 4; h++) begin
      step(1, 4'd7);
      checks++;
      if (locked !== 1'b1 || dir !== 1'b1 || {wrap_pulse, rev_pulse, err_pulse} !== 3'b000) begin
        errors++;
        $display("FAIL hold h=%0d got l=%b d=%b pulses=%b exp l=1 d=1 pulses=000",
                 h, locked, dir, {wrap_pulse, rev_pulse, err_pulse});
      end
    end
    step(1, 4'd8);
    checks++;
    if (locked !== 1'b1 || {wrap_pulse, rev_pulse, err_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL hold_resume got l=%b pulses=%b exp l=1 pulses=000",
               locked, {wrap_pulse, rev_pulse, err_pulse});
    end
  endtask

  task automatic test_err_saturate();
    logic [3:0] seq     [17] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0,
                                 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0};
    logic [1:0] exp_cnt [17] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic       exp_err [17] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    logic       exp_lck [17] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, seq[i]);
      checks++;
      if (err_count2 !== exp_cnt[i] || err_pulse2 !== exp_err[i] || locked2 !== exp_lck[i]) begin
        errors++;
        $display("FAIL err_sat i=%0d got cnt=%0d e=%b l=%b exp cnt=%0d e=%b l=%b",
                 i, err_count2, err_pulse2, locked2, exp_cnt[i], exp_err[i], exp_lck[i]);
      end
    end
    checks++;
    if (err_count !== 8'd4) begin
      errors++;
      $display("FAIL err_wide got cnt=%0d exp 4", err_count);
    end
    step(1, 4'd1);
    step(1, 4'd2);
    step(1, 4'd3);
    step(0, 4'd3);
    checks++;
    if (locked2 !== 1'b1 || err_count2 !== 2'd3) begin
      errors++;
      $display("FAIL pre_async_reset got l=%b cnt=%0d exp l=1 cnt=3", locked2, err_count2);
    end
    // Assert reset between edges and look before any further rising edge.
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({locked2, dir2, wrap_pulse2, rev_pulse2, err_pulse2} !== 5'b01000 || err_count2 !== 2'd0 ||
        locked !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got l=%b d=%b w=%b r=%b e=%b cnt=%0d wide_l=%b wide_cnt=%0d exp 0 1 0 0 0 0 0 0",
               locked2, dir2, wrap_pulse2, rev_pulse2, err_pulse2, err_count2, locked, err_count);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lock_up();
    test_wrap();
    test_reverse();
    test_rev_wrap();
    test_jump();
    test_invalid_and_hold();
    test_err_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
